// File: rtl/puf_pkg.sv
// Shared types and defaults for the PUF read sequencer and its vote accumulator.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE, RST, EXCITE, HOLD, CAPTURE, OUTPUT, FINISH
  } puf_state_t;

  localparam int ADDR_BITS_D     = 4;
  localparam int OUT_BITS_D      = 8;
  localparam int EVALS_D         = 5;
  localparam int RST_CYCLES_D    = 2;
  localparam int SETTLE_CYCLES_D = 8;

  // Wide enough to hold the value EVALS, so a one-counter never overflows.
  function automatic int cnt_w(input int evals);
    return $clog2(evals + 1);
  endfunction

endpackage

// File: rtl/puf_vote_acc.sv
// Per-bit one-counters with majority vote and disagreement flags.
// Disagreement flags exist only when PUF_CTRL_UNSTABLE_MASK_EN is defined.
module puf_vote_acc
  import puf_pkg::*;
#(
  parameter int OUT_BITS = OUT_BITS_D,
  parameter int EVALS    = EVALS_D
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_clr,
  input  logic                i_acc,
  input  logic [OUT_BITS-1:0] i_bits,
  output logic [OUT_BITS-1:0] o_major,
  output logic [OUT_BITS-1:0] o_unstable
);
  localparam int CW = cnt_w(EVALS);

  logic [OUT_BITS-1:0][CW-1:0] r_ones;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_ones <= '0;
    end else if (i_acc) begin
      for (int i = 0; i < OUT_BITS; i++)
        r_ones[i] <= r_ones[i] + CW'(i_bits[i]);
    end
  end

  for (genvar g = 0; g < OUT_BITS; g++) begin : g_bit
    assign o_major[g] = (r_ones[g] > CW'(EVALS / 2));
`ifdef PUF_CTRL_UNSTABLE_MASK_EN
    assign o_unstable[g] = (r_ones[g] != '0) && (r_ones[g] != CW'(EVALS));
`else
    assign o_unstable[g] = 1'b0;
`endif
  end

endmodule

// File: rtl/puf_read_controller.sv
// Sweeps every PUF address, majority-votes EVALS evaluations per word and streams words out.
// Optional per-bit disagreement flags: define PUF_CTRL_UNSTABLE_MASK_EN.
module puf_read_controller
  import puf_pkg::*;
#(
  parameter int ADDR_BITS     = ADDR_BITS_D,
  parameter int OUT_BITS      = OUT_BITS_D,
  parameter int EVALS         = EVALS_D,
  parameter int RST_CYCLES    = RST_CYCLES_D,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_D
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  output logic                 busy,
  output logic                 puf_reset,
  output logic                 puf_start,
  output logic [ADDR_BITS-1:0] puf_addr,
  input  logic [OUT_BITS-1:0]  puf_data,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic [ADDR_BITS-1:0] word_addr,
  output logic [OUT_BITS-1:0]  word_data,
  output logic [OUT_BITS-1:0]  word_unstable,
  output logic                 done
);
  localparam int TMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int EW   = cnt_w(EVALS);

  puf_state_t           r_state, w_nxt;
  logic [TW-1:0]        r_tmr;
  logic [EW-1:0]        r_eval;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 w_hs, w_start, w_last_eval;

  assign w_hs        = (r_state == OUTPUT) && word_ready;
  assign w_start     = (r_state == IDLE) && req;
  assign w_last_eval = (r_eval == EW'(EVALS - 1));
  assign puf_addr    = r_addr;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (req) w_nxt = RST;
      RST:     if (r_tmr == TW'(RST_CYCLES - 1)) w_nxt = EXCITE;
      EXCITE:  if (r_tmr == TW'(SETTLE_CYCLES - 1)) w_nxt = HOLD;
      HOLD:    w_nxt = CAPTURE;
      CAPTURE: w_nxt = w_last_eval ? OUTPUT : RST;
      OUTPUT:  if (word_ready) w_nxt = (&r_addr) ? FINISH : RST;
      FINISH:  w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tmr      <= '0;
      r_eval     <= '0;
      r_addr     <= '0;
      busy       <= 1'b0;
      puf_reset  <= 1'b1;
      puf_start  <= 1'b0;
      word_valid <= 1'b0;
      word_addr  <= '0;
      done       <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_tmr   <= (w_nxt != r_state) ? '0 : r_tmr + TW'(1);
      if (w_start || w_hs)
        r_eval <= '0;
      else if (r_state == CAPTURE && !w_last_eval)
        r_eval <= r_eval + EW'(1);
      if (w_start)
        r_addr <= '0;
      else if (w_hs && !(&r_addr))
        r_addr <= r_addr + ADDR_BITS'(1);
      if (w_nxt == OUTPUT && r_state != OUTPUT)
        word_addr <= r_addr;
      busy       <= (w_nxt != IDLE);
      puf_reset  <= (w_nxt == IDLE) || (w_nxt == RST);
      puf_start  <= (w_nxt == EXCITE);
      word_valid <= (w_nxt == OUTPUT);
      done       <= (w_nxt == FINISH);
    end
  end

  puf_vote_acc #(.OUT_BITS(OUT_BITS), .EVALS(EVALS)) u_vote (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_start || w_hs),
    .i_acc      (r_state == CAPTURE),
    .i_bits     (puf_data),
    .o_major    (word_data),
    .o_unstable (word_unstable)
  );

endmodule

// File: tb/tb_puf_read_controller.sv
// Scoreboard bench for puf_read_controller: array model with per-evaluation data tables.
module tb_puf_read_controller;
  localparam int AB = 4, OB = 8, EV = 5, NW = 16;
  localparam int WORD_CYC = EV * (2 + 8 + 2) + 1;

  logic          clk = 0, reset = 1, req = 0, word_ready = 0;
  logic          busy, puf_reset, puf_start, word_valid, done;
  logic [AB-1:0] puf_addr, word_addr;
  logic [OB-1:0] puf_data = '0, word_data, word_unstable;

  typedef struct { logic [AB-1:0] a; logic [OB-1:0] d; logic [OB-1:0] u; } exp_t;
  exp_t sb[$];

  logic [OB-1:0] tbl [NW][EV];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, ev_idx = 0, done_cnt = 0, done_cyc = 0, req_cyc = 0;
  logic start_d = 0;

  puf_read_controller dut (
    .clk(clk), .reset(reset), .req(req), .busy(busy), .puf_reset(puf_reset),
    .puf_start(puf_start), .puf_addr(puf_addr), .puf_data(puf_data),
    .word_valid(word_valid), .word_ready(word_ready), .word_addr(word_addr),
    .word_data(word_data), .word_unstable(word_unstable), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Array model: its output register captures the frozen word on the cycle after START falls;
  // at every other edge it shows noise so a mistimed capture corrupts the vote.
  always @(posedge clk) begin
    if (start_d && !puf_start) begin
      puf_data <= tbl[puf_addr][ev_idx];
      ev_idx   <= (ev_idx == EV - 1) ? 0 : ev_idx + 1;
    end else begin
      puf_data <= OB'($urandom);
    end
    if (reset || !busy) ev_idx <= 0;
    start_d <= puf_start;
  end

  // Monitor: pop and compare on every accepted word.
  always @(negedge clk) begin
    if (!reset && word_valid && word_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 32'(word_addr), 32'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("word_addr", 32'(word_addr), 32'(e.a));
        chk("word_data", 32'(word_data), 32'(e.d));
        chk("word_unstable", 32'(word_unstable), 32'(e.u));
      end
    end
    if (!reset && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic gen_tbl(input bit directed);
    logic [EV-1:0] pat;
    pat = 5'b01101;  // addr 0 bit 0 reads 1,0,1,1,0
    for (int a = 0; a < NW; a++)
      for (int e = 0; e < EV; e++) tbl[a][e] = OB'($urandom);
    if (directed)
      for (int e = 0; e < EV; e++) begin
        tbl[3][e]    = 8'hA5;
        tbl[0][e][0] = pat[e];
      end
  endtask

  // Reference vote: count ones per bit across the evaluations of each address.
  task automatic push_exp();
    for (int a = 0; a < NW; a++) begin
      exp_t x;
      x.a = AB'(a); x.d = '0; x.u = '0;
      for (int b = 0; b < OB; b++) begin
        int ones;
        ones = 0;
        for (int e = 0; e < EV; e++) ones += int'(tbl[a][e][b]);
        x.d[b] = (ones > EV / 2);
`ifdef PUF_CTRL_UNSTABLE_MASK_EN
        x.u[b] = (ones != 0) && (ones != EV);
`endif
      end
      sb.push_back(x);
    end
  endtask

  task automatic issue_req();
    push_exp();
    done_cnt = 0;
    @(posedge clk); #1 req = 1; req_cyc = cyc;
    @(posedge clk); #1 req = 0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_cnt == 0 && t < 3000) begin @(negedge clk); t++; end
    chk({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_puf_reset"}, 32'(puf_reset), 1);
    chk({name, "_puf_start"}, 32'(puf_start), 0);
    chk({name, "_puf_addr"}, 32'(puf_addr), 0);
    chk({name, "_word_valid"}, 32'(word_valid), 0);
    chk({name, "_word_addr"}, 32'(word_addr), 0);
    chk({name, "_word_data"}, 32'(word_data), 0);
    chk({name, "_word_unstable"}, 32'(word_unstable), 0);
    chk({name, "_done"}, 32'(done), 0);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 reset = 0;

    // Sweep 1: directed words, ready high, latency, extra reqs while busy.
    gen_tbl(1);
    word_ready = 1;
    issue_req();
    t = 0;
    while (!word_valid && t < 200) begin @(negedge clk); t++; end
    chk("first_valid_latency", 32'(cyc - req_cyc), 32'(WORD_CYC));
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(50, 200)) @(posedge clk);
      #1 req = 1;
      @(posedge clk); #1 req = 0;
    end
    wait_done("sweep1");
    chk("sweep1_done_time", 32'(done_cyc - req_cyc), 32'(NW * WORD_CYC + 1));
    @(negedge clk);
    chk("sweep1_busy_after_done", 32'(busy), 0);
    repeat (80) @(negedge clk);
    chk("sweep1_single_done", 32'(done_cnt), 1);
    chk("sweep1_no_restart", 32'(busy), 0);
    chk("sweep1_words_left", 32'(sb.size()), 0);

    // Sweep 2: backpressure with a 20-cycle stall on addr 2, random stalls elsewhere.
    gen_tbl(0);
    word_ready = 0;
    issue_req();
    for (int w = 0; w < NW; w++) begin
      logic [AB-1:0] sa, spa;
      logic [OB-1:0] sd;
      int stall;
      t = 0;
      @(negedge clk);
      while (!word_valid && t < 200) begin @(negedge clk); t++; end
      if (!word_valid) chk("bp_valid_timeout", 0, 1);
      sa = word_addr; sd = word_data; spa = puf_addr;
      stall = (w == 2) ? 20 : $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); @(negedge clk);
        if (w == 2) begin
          chk("bp_valid", 32'(word_valid), 1);
          chk("bp_addr", 32'(word_addr), 32'(sa));
          chk("bp_data", 32'(word_data), 32'(sd));
          chk("bp_puf_addr", 32'(puf_addr), 32'(spa));
          chk("bp_no_start", 32'(puf_start), 0);
        end
      end
      @(posedge clk); #1 word_ready = 1;
      @(posedge clk); #1 word_ready = 0;
      @(negedge clk);
      if (w == NW - 1) chk("bp_finish_done", 32'(done), 1);
      else chk("bp_next_rst", 32'({puf_reset, puf_start, busy}), 32'b101);
    end
    wait_done("sweep2");
    chk("sweep2_single_done", 32'(done_cnt), 1);

    // Sweep 3: reset while addr 7 is in EXCITE.
    repeat (5) @(posedge clk);
    gen_tbl(0);
    word_ready = 1;
    issue_req();
    t = 0;
    @(negedge clk);
    while (!(puf_addr == 7 && puf_start) && t < 2000) begin @(negedge clk); t++; end
    chk("addr7_excite_reached", 32'(puf_addr == 7 && puf_start), 1);
    reset = 1;
    @(negedge clk);
    check_reset_outputs("midreset");
    sb.delete();
    @(posedge clk); #1 reset = 0;

    // Sweep 4: restart from addr 0 after the mid-sweep reset.
    gen_tbl(1);
    issue_req();
    t = 0;
    while (!word_valid && t < 200) begin @(negedge clk); t++; end
    chk("restart_first_addr", 32'(word_addr), 0);
    wait_done("sweep4");
    repeat (5) @(negedge clk);
    chk("sweep4_single_done", 32'(done_cnt), 1);
    chk("sweep4_words_left", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
